// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the mips_32 unified-memory boot sequencer/arbiter.
package mips_mem_pkg;

  localparam int unsigned AW_DEF         = 10;
  localparam int unsigned DW_DEF         = 32;
  localparam int unsigned MAX_STARVE_DEF = 3;

  // Grant vector bit positions
  localparam int unsigned GNT_IF = 0;
  localparam int unsigned GNT_D  = 1;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/mips_mem_sched_if.sv
// Loader, fetch, data, core-control and memory-side signals of mips_mem_sched.
interface mips_mem_sched_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
);
  logic          ld_start;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_ready;
  logic          ld_done;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          core_halted;
  logic          core_stall;
  logic          core_start;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [1:0]    state;

  modport slave (
    input  ld_start, ld_valid, ld_addr, ld_wdata, ld_done,
    output ld_ready,
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    input  core_halted,
    output core_stall, core_start,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output state
  );

  modport master (
    output ld_start, ld_valid, ld_addr, ld_wdata, ld_done,
    input  ld_ready,
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    output core_halted,
    input  core_stall, core_start,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  state
  );
endinterface

// File: rtl/mips_mem_prio_arb.sv
// Two-way arbiter: data wins conflicts unless fetch has lost MAX_STARVE in a row.
module mips_mem_prio_arb
  import mips_mem_pkg::*;
#(
  parameter int unsigned MAX_STARVE = MAX_STARVE_DEF
) (
  input  logic       clk1,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       if_req,
  input  logic       d_req,
  output logic [1:0] gnt
);

  localparam int unsigned CW = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_STARVE);

  logic [CW-1:0] starve_cnt;
  logic          conflict;
  logic          if_win;

  always_comb begin
    conflict    = enable & if_req & d_req;
    if_win      = enable & if_req & (~d_req | (starve_cnt == CMAX));
    gnt         = '0;
    gnt[GNT_IF] = if_win;
    gnt[GNT_D]  = enable & d_req & ~if_win;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (if_win) begin
      starve_cnt <= '0;
    end else if (conflict && (starve_cnt != CMAX)) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mips_mem_sched.sv
// Boot sequencer and IF/MEM arbiter for the single-ported unified memory of mips_32.
module mips_mem_sched
  import mips_mem_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned MAX_STARVE = MAX_STARVE_DEF
) (
  input  logic             clk1,
  input  logic             rst_n,
  mips_mem_sched_if.slave  bus
);

  state_t     st;
  owner_t     owner;
  logic       core_start_q;
  logic       boot, run, halt;
  logic       ld_acc;
  logic [1:0] gnt;

  assign boot = (st == ST_BOOT);
  assign run  = (st == ST_RUN);
  assign halt = (st == ST_HALT);

  // Fetch is only offered to the arbiter in RUN; in HALT data alone competes.
  mips_mem_prio_arb #(.MAX_STARVE(MAX_STARVE)) u_arb (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .enable (run | halt),
    .if_req (bus.if_req & run),
    .d_req  (bus.d_req),
    .gnt    (gnt)
  );

  always_comb begin
    ld_acc         = boot & bus.ld_valid;
    bus.ld_ready   = ld_acc;
    bus.if_gnt     = gnt[GNT_IF];
    bus.d_gnt      = gnt[GNT_D];
    bus.core_stall = run ? (bus.if_req & ~gnt[GNT_IF]) : 1'b1;
    bus.core_start = core_start_q;
    bus.state      = st;

    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (ld_acc) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = bus.ld_addr;
      bus.mem_wdata = bus.ld_wdata;
    end else if (gnt[GNT_IF]) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.if_addr;
    end else if (gnt[GNT_D]) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.d_we;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      st           <= ST_BOOT;
      core_start_q <= 1'b0;
      owner        <= OWN_NONE;
    end else begin
      core_start_q <= 1'b0;
      case (st)
        ST_BOOT: if (bus.ld_done) begin
          st           <= ST_RUN;
          core_start_q <= 1'b1;
        end
        ST_RUN:  if (bus.core_halted) st <= ST_HALT;
        ST_HALT: if (bus.ld_start)    st <= ST_BOOT;
        default: st <= ST_BOOT;
      endcase

      if (gnt[GNT_IF])                     owner <= OWN_IF;
      else if (gnt[GNT_D] && !bus.d_we)    owner <= OWN_D;
      else                                 owner <= OWN_NONE;
    end
  end

  // mem_rdata is valid the cycle after the read, so the tag gates it directly.
  always_comb begin
    bus.if_rvalid = (owner == OWN_IF);
    bus.d_rvalid  = (owner == OWN_D);
    bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
    bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : '0;
  end

endmodule

// File: tb/tb_mips_mem_sched.sv
// Directed bench for mips_mem_sched with a behavioural single-port memory.
module tb_mips_mem_sched;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic clk1;
  logic rst_n;
  int   checks;
  int   errors;
  int   wr_cnt;

  logic [DW-1:0] mem [2**AW];

  mips_mem_sched_if #(.AW(AW), .DW(DW)) bus ();

  mips_mem_sched #(.AW(AW), .DW(DW), .MAX_STARVE(3)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  initial bus.mem_rdata = '0;

  always @(posedge clk1) begin
    if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ld_start = 0; bus.ld_valid = 0; bus.ld_addr = '0; bus.ld_wdata = '0; bus.ld_done = 0;
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.core_halted = 0;
  endtask

  initial begin
    checks = 0; errors = 0; wr_cnt = 0;
    rst_n = 1'b0;
    idle_inputs();

    // Reset state
    @(negedge clk1); @(negedge clk1); #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_stall", 32'(bus.core_stall), 32'd1);
    chk("rst_start", 32'(bus.core_start), 32'd0);
    chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    rst_n = 1'b1;

    // Boot load of three words; fetch/data requests must be refused in BOOT
    @(negedge clk1);
    bus.ld_valid = 1; bus.ld_addr = 10'd0; bus.ld_wdata = 32'h28010009;
    bus.if_req = 1; bus.d_req = 1;
    #1;
    chk("boot_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("boot_if_gnt", 32'(bus.if_gnt), 32'd0);
    chk("boot_d_gnt", 32'(bus.d_gnt), 32'd0);
    chk("boot_mem_we", 32'(bus.mem_we), 32'd1);
    chk("boot_mem_wdata", bus.mem_wdata, 32'h28010009);
    @(negedge clk1);
    bus.if_req = 0; bus.d_req = 0;
    bus.ld_addr = 10'd1; bus.ld_wdata = 32'h40000008;
    #1 chk("boot_mem_addr1", 32'(bus.mem_addr), 32'd1);
    @(negedge clk1);
    bus.ld_addr = 10'd2; bus.ld_wdata = 32'hFC000000; bus.ld_done = 1;
    #1 chk("boot_last_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("boot_last_state", 32'(bus.state), 32'd0);
    @(negedge clk1);
    idle_inputs();
    #1;
    chk("boot_writes", 32'(wr_cnt), 32'd3);
    chk("run_state", 32'(bus.state), 32'd1);
    chk("run_start_pulse", 32'(bus.core_start), 32'd1);
    chk("run_stall", 32'(bus.core_stall), 32'd0);
    chk("run_ld_ready", 32'(bus.ld_ready), 32'd0);

    // Fetch with one-cycle latency
    @(negedge clk1);
    bus.if_req = 1; bus.if_addr = 10'd1;
    #1;
    chk("run_start_cleared", 32'(bus.core_start), 32'd0);
    chk("fetch_gnt", 32'(bus.if_gnt), 32'd1);
    chk("fetch_mem_addr", 32'(bus.mem_addr), 32'd1);
    chk("fetch_stall", 32'(bus.core_stall), 32'd0);
    @(negedge clk1);
    bus.if_req = 0;
    #1;
    chk("fetch_rvalid", 32'(bus.if_rvalid), 32'd1);
    chk("fetch_rdata", bus.if_rdata, 32'h40000008);
    chk("fetch_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    chk("fetch_d_rdata", bus.d_rdata, 32'd0);

    // Conflict: expected grants D,D,D,IF,D
    @(negedge clk1);
    bus.if_req = 1; bus.if_addr = 10'd0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 10'd2;
    #1;
    chk("cf1_d_gnt", 32'(bus.d_gnt), 32'd1);
    chk("cf1_if_gnt", 32'(bus.if_gnt), 32'd0);
    chk("cf1_stall", 32'(bus.core_stall), 32'd1);
    @(negedge clk1); #1;
    chk("cf2_d_gnt", 32'(bus.d_gnt), 32'd1);
    chk("cf2_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    chk("cf2_d_rdata", bus.d_rdata, 32'hFC000000);
    @(negedge clk1); #1;
    chk("cf3_d_gnt", 32'(bus.d_gnt), 32'd1);
    chk("cf3_if_gnt", 32'(bus.if_gnt), 32'd0);
    @(negedge clk1); #1;
    chk("cf4_if_gnt", 32'(bus.if_gnt), 32'd1);
    chk("cf4_d_gnt", 32'(bus.d_gnt), 32'd0);
    chk("cf4_stall", 32'(bus.core_stall), 32'd0);
    @(negedge clk1); #1;
    chk("cf5_d_gnt", 32'(bus.d_gnt), 32'd1);
    chk("cf5_stall", 32'(bus.core_stall), 32'd1);
    chk("cf5_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    chk("cf5_if_rdata", bus.if_rdata, 32'h28010009);
    chk("cf5_d_rvalid", 32'(bus.d_rvalid), 32'd0);

    // Store then load at address 200
    @(negedge clk1);
    bus.if_req = 0;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 10'd200; bus.d_wdata = 32'd7;
    #1;
    chk("st_gnt", 32'(bus.d_gnt), 32'd1);
    chk("st_mem_we", 32'(bus.mem_we), 32'd1);
    chk("st_mem_addr", 32'(bus.mem_addr), 32'd200);
    chk("st_mem_wdata", bus.mem_wdata, 32'd7);
    @(negedge clk1);
    bus.d_we = 0;
    #1;
    chk("ld_gnt", 32'(bus.d_gnt), 32'd1);
    chk("ld_mem_we", 32'(bus.mem_we), 32'd0);
    chk("st_no_rvalid", 32'(bus.d_rvalid), 32'd0);
    @(negedge clk1);
    bus.d_req = 0;
    #1;
    chk("ld_rvalid", 32'(bus.d_rvalid), 32'd1);
    chk("ld_rdata", bus.d_rdata, 32'd7);
    chk("ld_if_rvalid", 32'(bus.if_rvalid), 32'd0);

    // ld_start in RUN is ignored
    @(negedge clk1);
    bus.ld_start = 1;
    @(negedge clk1);
    bus.ld_start = 0;
    #1 chk("run_ignore_ld_start", 32'(bus.state), 32'd1);

    // Halt with a load granted in the last RUN cycle
    @(negedge clk1);
    bus.core_halted = 1; bus.d_req = 1; bus.d_addr = 10'd1;
    #1;
    chk("h1_state", 32'(bus.state), 32'd1);
    chk("h1_d_gnt", 32'(bus.d_gnt), 32'd1);
    @(negedge clk1);
    bus.core_halted = 0; bus.if_req = 1; bus.d_addr = 10'd0; bus.ld_valid = 1;
    #1;
    chk("h2_state", 32'(bus.state), 32'd2);
    chk("h2_if_gnt", 32'(bus.if_gnt), 32'd0);
    chk("h2_d_gnt", 32'(bus.d_gnt), 32'd1);
    chk("h2_stall", 32'(bus.core_stall), 32'd1);
    chk("h2_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("h2_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    chk("h2_d_rdata", bus.d_rdata, 32'h40000008);
    @(negedge clk1);
    idle_inputs();
    bus.ld_start = 1;
    #1;
    chk("h3_state", 32'(bus.state), 32'd2);
    chk("h3_d_rdata", bus.d_rdata, 32'h28010009);
    @(negedge clk1);
    idle_inputs();
    bus.ld_valid = 1; bus.ld_addr = 10'd5; bus.ld_wdata = 32'h00000055;
    #1;
    chk("reboot_state", 32'(bus.state), 32'd0);
    chk("reboot_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("reboot_mem_we", 32'(bus.mem_we), 32'd1);
    @(negedge clk1);
    bus.ld_valid = 0; bus.ld_done = 1;
    #1 chk("reboot_ld_ready_low", 32'(bus.ld_ready), 32'd0);
    @(negedge clk1);
    bus.ld_done = 0;
    #1 chk("rerun_start", 32'(bus.core_start), 32'd1);

    // Reset while a fetch read is in flight
    @(negedge clk1);
    bus.if_req = 1; bus.if_addr = 10'd5;
    #1 chk("pre_rst_if_gnt", 32'(bus.if_gnt), 32'd1);
    @(negedge clk1);
    bus.if_req = 0;
    chk("pre_rst_if_rvalid", 32'(bus.if_rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(bus.state), 32'd0);
    chk("mid_rst_stall", 32'(bus.core_stall), 32'd1);
    chk("mid_rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("mid_rst_start", 32'(bus.core_start), 32'd0);
    @(negedge clk1); #1;
    chk("post_rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
